cam_window_writer: RTL and testbench
====================================

Name: cam_window_writer

Overview:
Parametrised successor to the fixed 256x256 camera-to-buffer capture path. It takes the synchronised camera pixel strobe stream (RGB565) in the system clock domain and tracks source x/y position. It selects a configurable window with optional integer decimation, then emits linear buffer write transactions in either RGB565 or 8-bit grayscale. It sits between the Camera pixel assembler (after CDC) and the Buffer write port. Freezing is frame-aligned, so the buffer always holds one complete frame.

Parameters:
SRC_W, 640, source pixels per line
SRC_H, 480, source lines per frame
WIN_X0, 0, window left column (source coords)
WIN_Y0, 0, window top line (source coords)
WIN_W, 256, window width in source pixels; must be a multiple of DECIM
WIN_H, 256, window height in source lines; must be a multiple of DECIM
DECIM, 1, keep every DECIMth pixel and line (1, 2 or 4)
ADDR_W, 16, buffer address width; elaboration error if (WIN_W/DECIM)*(WIN_H/DECIM) > 2**ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_valid  in  1  one-cycle strobe: pix_data holds the next pixel
pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0]
frame_done  in  1  one-cycle end-of-frame strobe
freeze  in  1  level: hold the current buffer contents
gray_mode  in  1  level: 1 = grayscale output, 0 = RGB565 passthrough
wr_en  out  1  buffer write enable, one cycle per write
wr_addr  out  ADDR_W  linear buffer address
wr_data  out  16  RGB565, or {8'h00, gray8} in gray mode
frame_ready  out  1  one-cycle pulse: complete window written
frame_err  out  1  one-cycle pulse: frame ended with the window incomplete
capturing  out  1  high in state CAPTURE

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset: wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, frame_err=0, capturing=0. All counters are cleared and the state is WAIT_SOF. Reset mid-frame discards the partial frame and cancels any in-flight write.
- States:
  - WAIT_SOF: ignore pix_valid. On frame_done, go to CAPTURE if freeze=0, otherwise go to FROZEN.
  - CAPTURE: process pixels. On frame_done, pulse frame_ready if the write count equals OUT_W*OUT_H, otherwise pulse frame_err. Then go to FROZEN if freeze=1, otherwise stay in CAPTURE with counters cleared.
  - FROZEN: no writes. On frame_done with freeze=0, go to CAPTURE.
  - freeze is sampled only on frame_done.
- Position counters:
  - x runs 0..SRC_W-1 and y runs 0..SRC_H-1, advancing on pix_valid.
  - At x=SRC_W-1, x wraps to 0 and y increments.
  - At y=SRC_H-1 with x=SRC_W-1, both wrap to 0. Extra pixels restart at the top of the frame.
  - frame_done clears x, y, the decimation phases and the address counter.
- Pixel selection: a pixel is kept when WIN_X0<=x<WIN_X0+WIN_W, WIN_Y0<=y<WIN_Y0+WIN_H, and both the column phase and the line phase relative to the window origin are 0 modulo DECIM. Phases are tracked with counters; no divider is used.
- Addressing:
  - OUT_W=WIN_W/DECIM and OUT_H=WIN_H/DECIM.
  - Kept pixels receive consecutive addresses 0..OUT_W*OUT_H-1 from a running counter; no multiplier is used.
  - The address never exceeds OUT_W*OUT_H-1. Writes beyond that count are suppressed.
- Pipeline: fixed latency of 2 clk cycles from pix_valid to wr_en in both modes.
  - Stage 1 registers the keep decision, address and data.
  - Stage 2 registers the gray conversion or passthrough.
  - Back-to-back pix_valid strobes produce back-to-back writes.
- Grayscale: expand to 8 bits per channel as R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. Then gray8=(77*R8+150*G8+29*B8)>>8, using an 18-bit intermediate and truncating.
- Simultaneous pix_valid and frame_done: frame_done wins and the coincident pixel is dropped. Writes already in flight in the pipeline still complete.
- gray_mode is sampled per pixel at stage 1.

Decomposition:
- Shared package cam_pkg:
  - RGB565 field bit positions
  - gray coefficients 77/150/29
  - state enum {WAIT_SOF, CAPTURE, FROZEN}
  - DECIM legal-value check function
- One sub-module: rgb565_to_gray, a registered one-stage conversion that supplies pipeline stage 2.

Test Plan:
- SRC_W=8, SRC_H=6, WIN_X0=2, WIN_Y0=1, WIN_W=4, WIN_H=4, DECIM=2. Drive frame_done, then 48 pixels with pix_data=y*8+x, then frame_done. Expect 4 writes with (addr, data) = (0,0x0A), (1,0x0C), (2,0x1A), (3,0x1C), followed by one frame_ready pulse.
- Gray mode with pixels 0xFFFF, 0xF800, 0x0000. Expect wr_data 0x00FF, 0x004C, 0x0000, each exactly 2 cycles after its pix_valid.
- Short frame: frame_done after 20 pixels. Expect frame_err=1 for one cycle, no frame_ready, and the next frame's writes start at addr 0.
- Freeze: set freeze=1 mid-frame. That frame completes with frame_ready, the next frame produces zero writes, and capture resumes one frame after freeze drops to 0.
- pix_valid coincident with frame_done at an in-window position. Expect no write for that pixel and counters at 0 on the next cycle.
- Reset asserted mid-window. On the next cycle all outputs are 0 and the state is WAIT_SOF; pixels before the next frame_done produce no writes.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared field positions, gray weights, state encoding and parameter checks for the camera window writer
package cam_pkg;
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;
  localparam logic [17:0] GRAY_R = 18'd77;
  localparam logic [17:0] GRAY_G = 18'd150;
  localparam logic [17:0] GRAY_B = 18'd29;
  typedef enum logic [1:0] {WAIT_SOF, CAPTURE, FROZEN} state_t;
  function automatic bit decim_ok(int d);
    return d == 1 || d == 2 || d == 4;
  endfunction
endpackage

// File: rtl/cam_window_writer_if.sv
// cam_window_writer_if: pixel strobe inputs, control levels and buffer write outputs
interface cam_window_writer_if #(
  parameter int ADDR_W = 16
);
  logic pix_valid;
  logic [15:0] pix_data;
  logic frame_done;
  logic freeze;
  logic gray_mode;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] wr_data;
  logic frame_ready;
  logic frame_err;
  logic capturing;
  modport master (
    output pix_valid, pix_data, frame_done, freeze, gray_mode,
    input wr_en, wr_addr, wr_data, frame_ready, frame_err, capturing
  );
  modport slave (
    input pix_valid, pix_data, frame_done, freeze, gray_mode,
    output wr_en, wr_addr, wr_data, frame_ready, frame_err, capturing
  );
endinterface

// File: rtl/rgb565_to_gray.sv
// rgb565_to_gray: registered RGB565 passthrough or 8-bit luma, zero-extended to 16 bits
module rgb565_to_gray
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix,
  input  logic        gray,
  output logic [15:0] dout
);
  logic [4:0] r5, b5;
  logic [5:0] g6;
  logic [17:0] r8, g8, b8, sum;
  always_comb begin
    r5 = pix[R_HI:R_LO];
    g6 = pix[G_HI:G_LO];
    b5 = pix[B_HI:B_LO];
    r8 = 18'({r5, r5[4:2]});
    g8 = 18'({g6, g6[5:4]});
    b8 = 18'({b5, b5[4:2]});
    sum = GRAY_R * r8 + GRAY_G * g8 + GRAY_B * b8;
  end
  always_ff @(posedge clk) begin
    dout <= rst ? '0 : gray ? {8'h00, 8'(sum >> 8)} : pix;
  end
endmodule

// File: rtl/cam_window_writer.sv
// cam_window_writer: tracks source x/y, keeps a decimated window and emits linear buffer writes
module cam_window_writer
  import cam_pkg::*;
#(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 256,
  parameter int WIN_H  = 256,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  cam_window_writer_if.slave bus
);
  localparam int OUT_W = WIN_W / DECIM;
  localparam int OUT_H = WIN_H / DECIM;
  localparam int TOTAL = OUT_W * OUT_H;
  localparam int XW = SRC_W > 1 ? $clog2(SRC_W) : 1;
  localparam int YW = SRC_H > 1 ? $clog2(SRC_H) : 1;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  if (!decim_ok(DECIM) || WIN_W % DECIM != 0 || WIN_H % DECIM != 0) begin : g_bad_decim
    $error("cam_window_writer: DECIM must be 1, 2 or 4 and divide WIN_W and WIN_H");
  end
  if (longint'(TOTAL) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("cam_window_writer: window does not fit in 2**ADDR_W buffer words");
  end
  if (WIN_X0 + WIN_W > SRC_W || WIN_Y0 + WIN_H > SRC_H) begin : g_bad_win
    $error("cam_window_writer: window exceeds source frame");
  end
  state_t st, nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] px, py;
  logic [ADDR_W:0] cnt;
  logic x_last, y_last, px_last, py_last, in_x, in_y, keep;
  logic s1_keep, s1_gray;
  logic [ADDR_W-1:0] s1_addr;
  logic [15:0] s1_data;
  always_comb begin
    x_last = int'(x) == SRC_W - 1;
    y_last = int'(y) == SRC_H - 1;
    px_last = int'(px) == DECIM - 1;
    py_last = int'(py) == DECIM - 1;
    in_x = int'(x) >= WIN_X0 && int'(x) < WIN_X0 + WIN_W;
    in_y = int'(y) >= WIN_Y0 && int'(y) < WIN_Y0 + WIN_H;
    keep = bus.pix_valid && !bus.frame_done && st == CAPTURE && in_x && in_y &&
           px == '0 && py == '0 && int'(cnt) < TOTAL;
    nxt = bus.frame_done ? (bus.freeze ? FROZEN : CAPTURE) : st;
  end
  // phases count kept-grid position within the window so no divider is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= WAIT_SOF;
      x <= '0;
      y <= '0;
      px <= '0;
      py <= '0;
      cnt <= '0;
      s1_keep <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_gray <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.capturing <= 1'b0;
    end else begin
      st <= nxt;
      bus.capturing <= nxt == CAPTURE;
      bus.frame_ready <= bus.frame_done && st == CAPTURE && int'(cnt) == TOTAL;
      bus.frame_err <= bus.frame_done && st == CAPTURE && int'(cnt) != TOTAL;
      s1_keep <= keep;
      s1_addr <= cnt[ADDR_W-1:0];
      s1_data <= bus.pix_data;
      s1_gray <= bus.gray_mode;
      bus.wr_en <= s1_keep;
      bus.wr_addr <= s1_addr;
      if (bus.frame_done) begin
        x <= '0;
        y <= '0;
        px <= '0;
        py <= '0;
        cnt <= '0;
      end else if (bus.pix_valid) begin
        x <= x_last ? '0 : x + 1'b1;
        px <= x_last ? '0 : in_x ? (px_last ? '0 : px + 1'b1) : px;
        if (x_last) begin
          y <= y_last ? '0 : y + 1'b1;
          py <= y_last ? '0 : in_y ? (py_last ? '0 : py + 1'b1) : py;
        end
        if (keep) cnt <= cnt + 1'b1;
      end
    end
  end
  rgb565_to_gray u_gray (
    .clk (clk),
    .rst (rst),
    .pix (s1_data),
    .gray(s1_gray),
    .dout(bus.wr_data)
  );
endmodule

// File: tb/tb_cam_window_writer.sv
// tb_cam_window_writer: directed and random frames checked cycle by cycle against a coordinate-level model
module tb_cam_window_writer;
  localparam int SRC_W = 8, SRC_H = 6, WIN_X0 = 2, WIN_Y0 = 1, WIN_W = 4, WIN_H = 4, DECIM = 2;
  localparam int ADDR_W = 4;
  localparam int TOTAL = (WIN_W / DECIM) * (WIN_H / DECIM);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cam_window_writer_if #(.ADDR_W(ADDR_W)) bus ();
  cam_window_writer #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .DECIM(DECIM), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_ready = 0, n_err = 0;
  int log_addr[$], log_data[$], log_cyc[$];
  bit armed = 0;
  int m_st = 0, m_x = 0, m_y = 0, m_cnt = 0;
  bit p_en = 0;
  int p_addr = 0, p_data = 0;
  bit e_en = 0, e_ready = 0, e_err = 0, e_cap = 0;
  int e_addr = 0, e_data = 0;
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic int gray_of(int d);
    int r5 = (d >> 11) & 31;
    int g6 = (d >> 5) & 63;
    int b5 = d & 31;
    int r8 = (r5 << 3) | (r5 >> 2);
    int g8 = (g6 << 2) | (g6 >> 4);
    int b8 = (b5 << 3) | (b5 >> 2);
    return (77 * r8 + 150 * g8 + 29 * b8) >> 8;
  endfunction
  function automatic bit kept(int x, int y);
    return x >= WIN_X0 && x < WIN_X0 + WIN_W && y >= WIN_Y0 && y < WIN_Y0 + WIN_H &&
           (x - WIN_X0) % DECIM == 0 && (y - WIN_Y0) % DECIM == 0;
  endfunction
  // model: state 0 = waiting for first frame, 1 = capturing, 2 = frozen
  always @(posedge clk) begin
    cyc++;
    armed = 1;
    if (rst) begin
      m_st = 0; m_x = 0; m_y = 0; m_cnt = 0; p_en = 0;
      e_en = 0; e_ready = 0; e_err = 0; e_cap = 0; e_addr = 0; e_data = 0;
    end else begin
      e_en = p_en;
      if (p_en) begin e_addr = p_addr; e_data = p_data; end
      p_en = 0;
      e_ready = bus.frame_done && m_st == 1 && m_cnt == TOTAL;
      e_err = bus.frame_done && m_st == 1 && m_cnt != TOTAL;
      if (bus.frame_done) begin
        m_st = bus.freeze ? 2 : 1; m_x = 0; m_y = 0; m_cnt = 0;
      end else if (bus.pix_valid) begin
        if (m_st == 1 && kept(m_x, m_y) && m_cnt < TOTAL) begin
          p_en = 1; p_addr = m_cnt; m_cnt++;
          p_data = bus.gray_mode ? gray_of(int'(bus.pix_data)) : int'(bus.pix_data);
        end
        m_x++;
        if (m_x == SRC_W) begin m_x = 0; m_y = (m_y + 1) % SRC_H; end
      end
      e_cap = m_st == 1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      check("wr_en", int'(bus.wr_en), int'(e_en));
      if (e_en) begin
        check("wr_addr", int'(bus.wr_addr), e_addr);
        check("wr_data", int'(bus.wr_data), e_data);
      end
      check("frame_ready", int'(bus.frame_ready), int'(e_ready));
      check("frame_err", int'(bus.frame_err), int'(e_err));
      check("capturing", int'(bus.capturing), int'(e_cap));
      if (bus.wr_en) begin
        log_addr.push_back(int'(bus.wr_addr));
        log_data.push_back(int'(bus.wr_data));
        log_cyc.push_back(cyc);
      end
      if (bus.frame_ready) n_ready++;
      if (bus.frame_err) n_err++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.frame_done = 1'b0;
  endtask
  task automatic pix(int d);
    bus.pix_valid = 1'b1;
    bus.pix_data = 16'(d);
    step();
  endtask
  task automatic fdone();
    bus.frame_done = 1'b1;
    step();
  endtask
  task automatic ramp(int from, int to);
    for (int i = from; i < to; i++) pix(i);
  endtask
  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask
  task automatic outputs_zero(string tag);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_ready"}, int'(bus.frame_ready), 0);
    check({tag, "_err"}, int'(bus.frame_err), 0);
    check({tag, "_capturing"}, int'(bus.capturing), 0);
  endtask
  task automatic full_window(string tag);
    int exp_d[4] = '{'h0A, 'h0C, 'h1A, 'h1C};
    check({tag, "_nwr"}, log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check({tag, "_addr"}, log_addr[i], i);
      check({tag, "_data"}, log_data[i], exp_d[i]);
    end
  endtask
  initial begin
    int r0, e0, pv_cyc[3];
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.frame_done = 1'b0;
    bus.freeze = 1'b0; bus.gray_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst = 1'b0;
    step();
    fdone();
    clear_log();
    r0 = n_ready;
    ramp(0, 48);
    step(); step();
    full_window("window");
    fdone();
    step();
    check("window_ready", n_ready - r0, 1);
    clear_log();
    r0 = n_ready;
    bus.gray_mode = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 10) pv_cyc[0] = cyc;
      if (i == 12) pv_cyc[1] = cyc;
      if (i == 26) pv_cyc[2] = cyc;
      pix(i == 10 ? 'hFFFF : i == 12 ? 'hF800 : i == 26 ? 'h0000 : 'h5555);
    end
    bus.gray_mode = 1'b0;
    fdone();
    step();
    check("gray_nwr", log_data.size(), 4);
    if (log_data.size() >= 3) begin
      check("gray_white", log_data[0], 'hFF);
      check("gray_red", log_data[1], 'h4C);
      check("gray_black", log_data[2], 'h00);
      for (int i = 0; i < 3; i++) check("gray_latency", log_cyc[i] - pv_cyc[i], 2);
    end
    check("gray_ready", n_ready - r0, 1);
    r0 = n_ready; e0 = n_err;
    ramp(0, 20);
    fdone();
    step();
    check("short_err", n_err - e0, 1);
    check("short_ready", n_ready - r0, 0);
    clear_log();
    ramp(0, 48);
    step(); step();
    full_window("after_short");
    r0 = n_ready;
    ramp(0, 0);
    fdone();
    step();
    check("after_short_ready", n_ready - r0, 1);
    r0 = n_ready; e0 = n_err;
    ramp(0, 20);
    bus.freeze = 1'b1;
    ramp(20, 48);
    fdone();
    step();
    check("freeze_ready", n_ready - r0, 1);
    check("frozen_capturing", int'(bus.capturing), 0);
    clear_log();
    ramp(0, 24);
    bus.freeze = 1'b0;
    ramp(24, 48);
    fdone();
    step();
    check("frozen_nwr", log_addr.size(), 0);
    check("frozen_pulses", (n_ready - r0) + (n_err - e0), 1);
    clear_log();
    ramp(0, 48);
    step(); step();
    full_window("resume");
    fdone();
    clear_log();
    e0 = n_err;
    ramp(0, 10);
    bus.pix_valid = 1'b1;
    bus.pix_data = 16'd10;
    fdone();
    step(); step(); step();
    check("coinc_nwr", log_addr.size(), 0);
    check("coinc_err", n_err - e0, 1);
    ramp(0, 48);
    step(); step();
    full_window("coinc_next");
    fdone();
    ramp(0, 13);
    rst = 1'b1;
    step();
    outputs_zero("midreset");
    rst = 1'b0;
    clear_log();
    ramp(0, 48);
    step(); step();
    check("postreset_nwr", log_addr.size(), 0);
    fdone();
    ramp(0, 48);
    step(); step();
    full_window("postreset");
    fdone();
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(10, 60);
      for (int i = 0; i < n; i++) begin
        bus.gray_mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) step();
        pix(int'($urandom_range(0, 65535)));
      end
      bus.freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        bus.pix_valid = 1'b1;
        bus.pix_data = 16'($urandom_range(0, 65535));
      end
      fdone();
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
